// File: rtl/configurable_switch_box.sv
// Purpose: four-sided FPGA-style switch box; each output track picks the same-index track of another side (or 0) from a 2-bit select held in an active config register loaded via a serial shadow chain.
// Latency: REG_OUT=1 gives one clk from track input or active-config change to track output; REG_OUT=0 is combinational. A commit takes effect on the mux the cycle after the commit edge.
// Backpressure: none; cfg_valid shifts unconditionally, and a commit before the chain is full is dropped and flagged on cfg_err.
module configurable_switch_box #(
  parameter int W       = 4,
  parameter int REG_OUT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] n_in,
  input  logic [W-1:0] e_in,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] w_in,
  output logic [W-1:0] n_out,
  output logic [W-1:0] e_out,
  output logic [W-1:0] s_out,
  output logic [W-1:0] w_out,
  input  logic         cfg_valid,
  input  logic         cfg_in,
  input  logic         cfg_commit,
  output logic         cfg_out,
  output logic         cfg_full,
  output logic         cfg_err
);

  localparam int NB = 8 * W;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NB);

  logic [NB-1:0]  r_shadow;
  logic [NB-1:0]  r_active;
  logic [CW-1:0]  r_cnt;
  logic           r_err;

  logic           w_full;
  logic           w_accept;
  logic           w_reject;
  logic [4*W-1:0] w_side;
  logic [4*W-1:0] w_mux;

  // Sides packed in index order N=0, E=1, S=2, W=3 so side x track k sits at bit x*W+k.
  assign w_side   = {w_in, s_in, e_in, n_in};

  assign w_full   = (r_cnt == FULL_CNT);
  assign w_accept = cfg_commit & w_full;
  assign w_reject = cfg_commit & ~w_full;

  assign cfg_out  = r_shadow[0];
  assign cfg_full = w_full;
  assign cfg_err  = r_err;

  // Shadow chain: shift right, new bit enters at the top so the first bit loaded ends at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (cfg_valid) begin
      r_shadow <= {cfg_in, r_shadow[NB-1:1]};
    end
  end

  // Active config: captures the pre-edge shadow only on an accepted commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
    end else if (w_accept) begin
      r_active <= r_shadow;
    end
  end

  // Bit counter: saturates at full; an accepted commit restarts it, counting a same-cycle shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= cfg_valid ? CW'(1) : '0;
    end else if (cfg_valid && !w_full) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Error flag: high for exactly the cycle after a rejected commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

  // Per-track mux: select s routes the same track index from side (x+s) mod 4.
  for (genvar x = 0; x < 4; x++) begin : g_side
    for (genvar k = 0; k < W; k++) begin : g_trk
      logic [1:0] w_sel;
      assign w_sel = r_active[(x*W+k)*2 +: 2];
      assign w_mux[x*W+k] = (w_sel == 2'd1) ? w_side[((x+1)%4)*W+k] :
                            (w_sel == 2'd2) ? w_side[((x+2)%4)*W+k] :
                            (w_sel == 2'd3) ? w_side[((x+3)%4)*W+k] : 1'b0;
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [4*W-1:0] r_out;

    // Output stage: one register per track, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out <= '0;
      end else begin
        r_out <= w_mux;
      end
    end

    assign n_out = r_out[0*W +: W];
    assign e_out = r_out[1*W +: W];
    assign s_out = r_out[2*W +: W];
    assign w_out = r_out[3*W +: W];
  end else begin : g_comb
    assign n_out = w_mux[0*W +: W];
    assign e_out = w_mux[1*W +: W];
    assign s_out = w_mux[2*W +: W];
    assign w_out = w_mux[3*W +: W];
  end

endmodule

// File: tb/tb_configurable_switch_box.sv
// Directed bench for configurable_switch_box (W=4, REG_OUT=1).
// Stimulus pushes expected values tagged with the cycle they must hold;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_configurable_switch_box;

  localparam int W = 4;

  localparam int SN = 0, SE = 1, SS = 2, SW = 3, SCO = 4, SFU = 5, SER = 6;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] n_in, e_in, s_in, w_in;
  logic [W-1:0] n_out, e_out, s_out, w_out;
  logic         cfg_valid, cfg_in, cfg_commit;
  logic         cfg_out, cfg_full, cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
    string      nm;
  } exp_t;

  exp_t q[$];

  configurable_switch_box #(.W(W), .REG_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .n_in(n_in), .e_in(e_in), .s_in(s_in), .w_in(w_in),
    .n_out(n_out), .e_out(e_out), .s_out(s_out), .w_out(w_out),
    .cfg_valid(cfg_valid), .cfg_in(cfg_in), .cfg_commit(cfg_commit),
    .cfg_out(cfg_out), .cfg_full(cfg_full), .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] pick(input int s);
    case (s)
      SN:  return n_out;
      SE:  return e_out;
      SS:  return s_out;
      SW:  return w_out;
      SCO: return {3'b000, cfg_out};
      SFU: return {3'b000, cfg_full};
      SER: return {3'b000, cfg_err};
      default: return 4'hx;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; late ones count as failures.
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act = pick(q[i].sig);
        checks++;
        if (q[i].cyc < cyc || act !== q[i].val) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                   q[i].nm, act, q[i].val, cyc, q[i].cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic push_exp(input int dc, input int sig, input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.val = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic push_routes(input int dc, input logic [3:0] n, input logic [3:0] e,
                             input logic [3:0] s, input logic [3:0] w, input string tag);
    push_exp(dc, SN, n, {tag, "_n"});
    push_exp(dc, SE, e, {tag, "_e"});
    push_exp(dc, SS, s, {tag, "_s"});
    push_exp(dc, SW, w, {tag, "_w"});
  endtask

  // One clock with the given config controls applied to that edge.
  task automatic step(input logic v, input logic b, input logic c);
    cfg_valid  = v;
    cfg_in     = b;
    cfg_commit = c;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) step(1'b1, word[i], 1'b0);
  endtask

  logic [31:0] c1, c2, c3, c4;

  initial begin
    // N tracks all sel=1 (east).
    c1 = 32'h0000_0055;
    // N: k0..k3 sel 1,2,3,0; E sel 3 (north); S sel 1 (west); W sel 2 (east).
    c2 = 32'hAA55_FF39;
    // N tracks all sel=3 (west).
    c3 = 32'h0000_00FF;
    c4 = 32'h0000_0001;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    n_in = 4'hF; e_in = 4'hF; s_in = 4'hF; w_in = 4'hF;
    @(posedge clk); #1;
    push_routes(0, 4'h0, 4'h0, 4'h0, 4'h0, "rst");
    push_exp(0, SCO, 4'h0, "rst_cfg_out");
    push_exp(0, SFU, 4'h0, "rst_cfg_full");
    push_exp(0, SER, 4'h0, "rst_cfg_err");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unconfigured box drives zeros whatever the inputs do.
    for (int i = 0; i < 3; i++) begin
      n_in = 4'($urandom_range(0, 15));
      e_in = 4'($urandom_range(0, 15));
      s_in = 4'($urandom_range(0, 15));
      w_in = 4'($urandom_range(0, 15));
      step(1'b0, 1'b0, 1'b0);
      push_routes(0, 4'h0, 4'h0, 4'h0, 4'h0, "idle_toggle");
    end
    push_exp(0, SFU, 4'h0, "idle_full");
    push_exp(0, SCO, 4'h0, "idle_cfg_out");

    n_in = 4'h9; e_in = 4'hA; s_in = 4'h3; w_in = 4'h7;

    // Full load of c1: shadow filled, routing not yet affected.
    shift_bits(c1, 32);
    push_exp(0, SFU, 4'h1, "c1_full");
    push_exp(0, SCO, 4'h1, "c1_cfg_out");
    push_exp(0, SN, 4'h0, "c1_no_route_before_commit");
    step(1'b0, 1'b0, 1'b1);
    push_exp(0, SFU, 4'h0, "c1_commit_full_clr");
    push_exp(0, SER, 4'h0, "c1_commit_no_err");
    push_routes(1, 4'hA, 4'h0, 4'h0, 4'h0, "c1_route");
    step(1'b0, 1'b0, 1'b0);
    e_in = 4'h5;
    step(1'b0, 1'b0, 1'b0);
    push_exp(0, SN, 4'h5, "c1_follow_e");
    e_in = 4'hA;
    step(1'b0, 1'b0, 1'b0);

    // 31 bits then commit: rejected, routing kept.
    shift_bits(c2, 31);
    push_exp(0, SFU, 4'h0, "c2_31_not_full");
    step(1'b0, 1'b0, 1'b1);
    push_exp(0, SER, 4'h1, "c2_early_err");
    push_exp(0, SFU, 4'h0, "c2_early_full");
    push_exp(1, SER, 4'h0, "c2_err_one_cycle");
    push_exp(1, SN, 4'hA, "c2_route_kept");
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, c2[31], 1'b0);
    push_exp(0, SFU, 4'h1, "c2_32_full");
    step(1'b0, 1'b0, 1'b1);
    push_exp(0, SER, 4'h0, "c2_commit_no_err");
    push_routes(1, 4'h6, 4'h9, 4'h7, 4'hA, "c2_route");
    step(1'b0, 1'b0, 1'b0);

    // Load c3 while cfg_out replays the c2 still sitting in the shadow.
    for (int j = 1; j <= 32; j++) begin
      step(1'b1, c3[j-1], 1'b0);
      push_exp(0, SCO, (j < 32) ? {3'b000, c2[j]} : {3'b000, c3[0]}, $sformatf("replay_%0d", j));
    end
    push_exp(0, SFU, 4'h1, "c3_full");

    // Shift and accepted commit together: active takes pre-shift shadow, cnt=1.
    step(1'b1, 1'b0, 1'b1);
    push_exp(0, SFU, 4'h0, "combo_full_clr");
    push_exp(0, SER, 4'h0, "combo_no_err");
    push_exp(1, SER, 4'h0, "combo_no_err_next");
    push_routes(1, 4'h7, 4'h0, 4'h0, 4'h0, "combo_route");

    // 31 more shifts (one with a rejected commit) reach full only if cnt restarted at 1.
    for (int i = 1; i <= 31; i++) begin
      if (i == 5) begin
        step(1'b1, 1'b1, 1'b1);
        push_exp(0, SER, 4'h1, "combo_reject_err");
      end else begin
        step(1'b1, 1'b1, 1'b0);
      end
      if (i == 6)  push_exp(0, SER, 4'h0, "combo_reject_err_clr");
      if (i == 30) push_exp(0, SFU, 4'h0, "cnt_30_not_full");
      if (i == 31) push_exp(0, SFU, 4'h1, "cnt_31_full");
    end

    // Commit held two cycles: first accepted, second rejected.
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    push_exp(0, SFU, 4'h0, "hold_accept_full");
    push_exp(0, SER, 4'h0, "hold_accept_no_err");
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    push_exp(0, SER, 4'h1, "hold_second_reject");
    push_routes(0, 4'h7, 4'h9, 4'hA, 4'h3, "hold_route");
    push_exp(1, SER, 4'h0, "hold_err_clr");
    step(1'b0, 1'b0, 1'b0);

    // Load 0x00000001, then shift ones while cfg_out replays it.
    shift_bits(c4, 32);
    push_exp(0, SFU, 4'h1, "c4_full");
    push_exp(0, SCO, 4'h1, "c4_cfg_out");
    for (int j = 1; j <= 15; j++) begin
      step(1'b1, 1'b1, 1'b0);
      push_exp(0, SCO, {3'b000, c4[j]}, $sformatf("c4_replay_%0d", j));
    end

    // Reset at shift 16: everything clears asynchronously.
    rst_n = 1'b0;
    push_routes(0, 4'h0, 4'h0, 4'h0, 4'h0, "midrst");
    push_exp(0, SCO, 4'h0, "midrst_cfg_out");
    push_exp(0, SFU, 4'h0, "midrst_full");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    push_exp(0, SER, 4'h1, "post_rst_commit_rejected");

    // Shadow must have been cleared: old bit 17 was a one.
    for (int j = 1; j <= 17; j++) step(1'b1, 1'b0, 1'b0);
    push_exp(0, SCO, 4'h0, "post_rst_shadow_clear");
    step(1'b0, 1'b0, 1'b1);
    push_exp(0, SER, 4'h1, "partial_load_rejected");
    push_exp(1, SN, 4'h0, "partial_load_route");
    step(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
      errors += q.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
